eth_packer: RTL and testbench
=============================

Name: eth_packer

Overview:
- Receive-side Ethernet frame checker on the RMII dibit stream.
- Upstream has already stripped the preamble/SFD. The block consumes the frame body (destination address through FCS) as 2-bit words while axiiv is high.
- Internally it packs the dibits into bytes and runs CRC-32 over the bit stream.
- When the frame ends it reports a one-cycle done strobe, with kill flagging a bad or malformed frame.

Parameters:
- MIN_BYTES, 4, minimum frame length in bytes (FCS only). Shorter frames are killed.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset: one clock, reset is synchronous and active-low (rst=0 resets on the clk edge).
- axiiv  input  1  dibit valid; high for every dibit of one frame, contiguous.
- axiid  input  2  dibit data.
- done  output  1  one-cycle strobe at frame end.
- kill  output  1  frame-bad flag; meaningful only while done=1, otherwise 0.

Behaviour:
Reset:
- rst=0 at a clk edge gives state=IDLE, done=0, kill=0, CRC=0xFFFFFFFF, dibit counter=0, byte counter=0.
- Reset mid-frame discards the frame and produces no done.

Bit order:
- Each dibit carries two serial bits: axiid[0] is the earlier bit, axiid[1] the later.
- Bytes arrive MSB first. Dibit k of a byte holds byte bits {7-2k (axiid[0]), 6-2k (axiid[1])}.
- The FCS is appended MSB first in the same way.

CRC:
- CRC-32/BZIP2 style: poly 0x04C11DB7, non-reflected, MSB-first shift register, init 0xFFFFFFFF.
- Update 2 bits per valid dibit, processing axiid[0] first, then axiid[1].
- Each bit step: fb = crc[31] ^ bit; crc = {crc[30:0],0} ^ (fb ? poly : 0).
- The CRC runs over the whole frame including the FCS.
- Frame is good iff the final register equals the residue 0xC704DD7B.

Packing:
- A 2-bit dibit counter wraps 3->0. The byte counter increments on each wrap and saturates at 2047.
- The assembled byte is internal only.

FSM:
- IDLE, axiiv=1: process the dibit (CRC update, counter=1) and go to RECV. axiiv=0: stay; done=0.
- RECV, axiiv=1: process the dibit.
- RECV, axiiv=0 (frame end): on this edge register done=1 and kill=bad, clear CRC and counters, go to IDLE.
- The dibit sampled with axiiv=0 is ignored.
- bad = (CRC != residue) OR (dibit counter != 0, i.e. not a whole number of bytes) OR (byte count < MIN_BYTES).

Timing:
- done rises at the clk edge after the first cycle in which axiiv is sampled low.
- done is high for exactly one cycle; kill equals bad in that cycle and is 0 otherwise.
- After done, IDLE accepts a new frame on the next cycle; the minimum inter-frame gap is 1 cycle.
- axiid is ignored whenever axiiv=0.
- An axiiv low of any length terminates the frame. There is no timeout and no maximum length check beyond counter saturation.

Test Plan:
- Reset check: hold rst=0 for 2 cycles, then release -> done=0, kill=0. Hold axiiv=0 for 32 cycles -> no done.
- Short garbage frame: axiiv=1 with dibits 0,1,2,3,0,1,2,3 then 32 x 01 (40 dibits, 10 bytes), then axiiv=0 -> done=1 for exactly one cycle, kill=1 (CRC mismatch), then done=0.
- Good frame: 8 idle cycles, then the 84 dibits of ASCII "Barry! Breakfast time" (21 bytes, MSB-first per the bit-order rule), then its 16-dibit CRC-32/BZIP2 FCS from the bench model, then axiiv=0 -> done=1, kill=0 one cycle after axiiv falls.
- Same 84 dibits without FCS, then axiiv=0 -> done=1, kill=1.
- Malformed frames:
  - Good frame with one dibit removed (99 dibits) -> done=1, kill=1 (partial byte).
  - 3-byte frame -> done=1, kill=1 (below MIN_BYTES).
- Back-to-back frames: good frame, then a 1-cycle gap, then the good frame again -> two done pulses, both kill=0.
- Reset mid-frame: rst=0 mid-frame -> no done; the next good frame still gives kill=0.

Source files
------------

// File: rtl/eth_packer.sv
// RMII receive-side frame checker: packs the dibit frame body, runs CRC-32
// over it and raises a one-cycle done strobe with kill on bad/malformed frames.
module eth_packer #(
    parameter int MIN_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       done,
    output logic       kill
);

    localparam logic [31:0] POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE = 32'hC704_DD7B;
    localparam logic [10:0] BCNT_MAX = 11'd2047;
    localparam logic [10:0] MIN_B    = 11'(MIN_BYTES);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;
    logic [31:0] w_crc_step;
    logic [1:0]  r_dcnt;
    logic [1:0]  w_dcnt_nxt;
    logic [10:0] r_bcnt;
    logic [10:0] w_bcnt_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic        w_bad;

    function automatic logic [31:0] crc_bit(
        input logic [31:0] c,
        input logic        b
    );
        logic fb;
        fb = c[31] ^ b;
        return {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    endfunction

    // axiid[0] is the earlier serial bit, so it enters the CRC first
    assign w_crc_step = crc_bit(crc_bit(r_crc, axiid[0]), axiid[1]);

    assign w_bad = (r_crc != RESIDUE)
                || (r_dcnt != 2'd0)
                || (r_bcnt < MIN_B);

    always_comb begin
        w_state_nxt = r_state;
        w_crc_nxt   = r_crc;
        w_dcnt_nxt  = r_dcnt;
        w_bcnt_nxt  = r_bcnt;
        w_done_nxt  = 1'b0;
        w_kill_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (axiiv) begin
                    w_crc_nxt   = w_crc_step;
                    w_dcnt_nxt  = 2'd1;
                    w_bcnt_nxt  = 11'd0;
                    w_state_nxt = RECV;
                end
            end
            RECV: begin
                if (axiiv) begin
                    w_crc_nxt  = w_crc_step;
                    w_dcnt_nxt = r_dcnt + 2'd1;
                    if (r_dcnt == 2'd3 && r_bcnt != BCNT_MAX) begin
                        w_bcnt_nxt = r_bcnt + 11'd1;
                    end
                end else begin
                    w_done_nxt  = 1'b1;
                    w_kill_nxt  = w_bad;
                    w_crc_nxt   = INIT;
                    w_dcnt_nxt  = 2'd0;
                    w_bcnt_nxt  = 11'd0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_crc   <= INIT;
            r_dcnt  <= 2'd0;
            r_bcnt  <= 11'd0;
            r_done  <= 1'b0;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_crc   <= w_crc_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_done  <= w_done_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    assign done = r_done;
    assign kill = r_kill;

endmodule

// File: tb/tb_eth_packer.sv
// Bench for eth_packer: directed and random frames against a frame-level
// reference model that judges each whole frame when axiiv falls.
module tb_eth_packer;

    localparam int          MIN_BYTES = 4;
    localparam logic [31:0] POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] RESIDUE   = 32'hC704_DD7B;

    typedef logic [1:0] dq_t[$];
    typedef logic [7:0] bq_t[$];

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       axiiv = 1'b0;
    logic [1:0] axiid = 2'd0;
    logic       done;
    logic       kill;

    int n_cmp = 0;
    int n_bad = 0;

    // dibits of the frame currently open in the model
    logic [1:0] m_q[$];

    eth_packer #(.MIN_BYTES(MIN_BYTES)) dut (
        .clk  (clk),
        .rst  (rst),
        .axiiv(axiiv),
        .axiid(axiid),
        .done (done),
        .kill (kill)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_of(input dq_t q);
        logic [31:0] c;
        logic        b;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            for (int k = 0; k < 2; k++) begin
                b = q[i][k];
                if (c[31] ^ b) c = (c << 1) ^ POLY;
                else           c = c << 1;
            end
        end
        return c;
    endfunction

    function automatic dq_t to_dibits(input bq_t b);
        dq_t d;
        foreach (b[i]) begin
            for (int k = 0; k < 4; k++) begin
                d.push_back({b[i][6-2*k], b[i][7-2*k]});
            end
        end
        return d;
    endfunction

    function automatic bq_t with_fcs(input bq_t b);
        bq_t         r;
        logic [31:0] f;
        r = b;
        f = ~crc_of(to_dibits(b));
        r.push_back(f[31:24]);
        r.push_back(f[23:16]);
        r.push_back(f[15:8]);
        r.push_back(f[7:0]);
        return r;
    endfunction

    function automatic bit is_bad(input dq_t q);
        return (q.size() % 4 != 0)
            || (q.size() / 4 < MIN_BYTES)
            || (crc_of(q) != RESIDUE);
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [1:0] d);
        logic ed;
        logic ek;
        rst   = r;
        axiiv = v;
        axiid = d;
        @(posedge clk);
        #1;
        ed = 1'b0;
        ek = 1'b0;
        if (!r) begin
            m_q.delete();
        end else if (v) begin
            m_q.push_back(d);
        end else if (m_q.size() > 0) begin
            ed = 1'b1;
            ek = is_bad(m_q);
            m_q.delete();
        end
        n_cmp++;
        assert (done === ed) else begin
            n_bad++;
            $error("FAIL done: got %b expected %b at %0t", done, ed, $time);
        end
        n_cmp++;
        assert (kill === ek) else begin
            n_bad++;
            $error("FAIL kill: got %b expected %b at %0t", kill, ek, $time);
        end
    endtask

    task automatic send(input dq_t q);
        foreach (q[i]) cyc(1'b1, 1'b1, q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 2'($urandom));
    endtask

    initial begin
        string s;
        bq_t   msg;
        bq_t   bb;
        dq_t   g;
        dq_t   good;
        dq_t   nofcs;
        dq_t   dq;
        int    len;
        int    mode;
        int    idx;

        s = "Barry! Breakfast time";
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
        good  = to_dibits(with_fcs(msg));
        nofcs = to_dibits(msg);

        cyc(1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 2'd0);
        idle(32);

        for (int i = 0; i < 8; i++) g.push_back(2'(i % 4));
        repeat (32) g.push_back(2'd1);
        send(g);
        idle(2);

        idle(8);
        send(good);
        idle(2);

        send(nofcs);
        idle(2);

        dq = good;
        dq.delete(50);
        send(dq);
        idle(2);

        bb.delete();
        bb.push_back(8'h12);
        bb.push_back(8'h34);
        bb.push_back(8'h56);
        send(to_dibits(bb));
        idle(2);

        bb.delete();
        send(to_dibits(with_fcs(bb)));
        idle(2);

        send(good);
        idle(1);
        send(good);
        idle(2);

        dq = good;
        dq = dq[0:39];
        send(dq);
        cyc(1'b0, 1'b1, 2'd3);
        idle(3);
        send(good);
        idle(2);

        repeat (30) begin
            len  = $urandom_range(0, 24);
            mode = $urandom_range(0, 3);
            bb.delete();
            repeat (len) bb.push_back(8'($urandom));
            if (mode == 3) dq = to_dibits(bb);
            else           dq = to_dibits(with_fcs(bb));
            if (mode == 1) begin
                idx = $urandom_range(0, dq.size() - 1);
                dq[idx] = dq[idx] ^ 2'($urandom_range(1, 3));
            end
            if (mode == 2 && dq.size() > 1) begin
                dq.delete($urandom_range(0, dq.size() - 1));
            end
            if (dq.size() > 0) send(dq);
            idle($urandom_range(1, 3));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
